dcache_ctrl: RTL and testbench

//  Miss-handling controller sitting directly upstream of D_SRAM in the L1 data cache.

---
 rtl/dcache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped L1 D-cache miss controller in front of D_SRAM
// Looks up each CPU access, writes back dirty victims, refills from next level, then replays.
module dcache_ctrl #(
    parameter int TAG_W     = 3,
    parameter int IDX_W     = 1,
    parameter int BLK_BYTES = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cpu_ren,
    input  logic                                     cpu_wen,
    input  logic [TAG_W+IDX_W+$clog2(BLK_BYTES)-1:0] cpu_addr,
    input  logic [31:0]                              cpu_wdata,
    input  logic [3:0]                               cpu_be,
    output logic [31:0]                              cpu_rdata,
    output logic                                     cpu_stall,
    output logic                                     sram_ren,
    output logic                                     sram_wen,
    output logic                                     sram_memWen,
    output logic [BLK_BYTES-1:0]                     sram_bytes,
    output logic [TAG_W+IDX_W-1:0]                   sram_baddr,
    output logic [8*BLK_BYTES-1:0]                   sram_din,
    input  logic                                     sram_hit,
    input  logic                                     sram_dirty,
    input  logic [8*BLK_BYTES-1:0]                   sram_dout,
    output logic                                     mem_req,
    output logic                                     mem_we,
    output logic [TAG_W+IDX_W-1:0]                   mem_addr,
    output logic [8*BLK_BYTES-1:0]                   mem_wdata,
    input  logic [8*BLK_BYTES-1:0]                   mem_rdata,
    input  logic                                     mem_ready
);
    localparam int OFF_W    = $clog2(BLK_BYTES);
    localparam int ADDR_W   = TAG_W + IDX_W + OFF_W;
    localparam int BLK_BITS = 8 * BLK_BYTES;
    localparam int WPB      = BLK_BYTES / 4;
    localparam int WORD_W   = OFF_W - 2;
    localparam int NSETS    = 1 << IDX_W;
    localparam int BA_W     = TAG_W + IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_RF   = 2'd2;
    localparam logic [1:0] S_FILL = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BA_W-1:0]     vaddr_q, vaddr_d;
    logic [BLK_BITS-1:0] victim_q, victim_d;
    logic [BLK_BITS-1:0] fill_q, fill_d;
    logic [TAG_W-1:0]    shadow_tag_q [NSETS];
    logic [TAG_W-1:0]    shadow_tag_d [NSETS];
    logic [NSETS-1:0]    valid_q, valid_d;

    logic                req;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   req_word;
    logic                addr_lsb_unused;

    assign req             = cpu_ren | cpu_wen;
    assign req_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx         = cpu_addr[OFF_W +: IDX_W];
    assign req_word        = cpu_addr[OFF_W-1:2];
    assign addr_lsb_unused = ^cpu_addr[1:0];

    // Outputs are forced to zero while reset is held so nothing leaks from a held CPU request.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        vaddr_d      = vaddr_q;
        victim_d     = victim_q;
        fill_d       = fill_q;
        shadow_tag_d = shadow_tag_q;
        valid_d      = valid_q;
        cpu_rdata    = '0;
        cpu_stall    = 1'b0;
        sram_ren     = 1'b0;
        sram_wen     = 1'b0;
        sram_memWen  = 1'b0;
        sram_bytes   = '0;
        sram_baddr   = '0;
        sram_din     = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        sram_ren   = 1'b1;
                        sram_baddr = {req_tag, req_idx};
                        if (sram_hit) begin
                            if (cpu_wen) begin
                                sram_wen   = 1'b1;
                                sram_bytes = BLK_BYTES'(cpu_be) << {req_word, 2'b00};
                                sram_din   = {WPB{cpu_wdata}};
                            end else begin
                                cpu_rdata = sram_dout[{req_word, 5'b00000} +: 32];
                            end
                        end else begin
                            cpu_stall = 1'b1;
                            tag_d     = req_tag;
                            idx_d     = req_idx;
                            // The shadow tag names the victim; D_SRAM only exposes its data and dirty bit.
                            if (sram_dirty && valid_q[req_idx]) begin
                                victim_d = sram_dout;
                                vaddr_d  = {shadow_tag_q[req_idx], req_idx};
                                state_d  = S_WB;
                            end else begin
                                state_d = S_RF;
                            end
                        end
                    end
                end
                S_WB: begin
                    cpu_stall = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = vaddr_q;
                    mem_wdata = victim_q;
                    if (mem_ready) begin
                        state_d = S_RF;
                    end
                end
                S_RF: begin
                    cpu_stall = 1'b1;
                    mem_req   = 1'b1;
                    mem_addr  = {tag_q, idx_q};
                    if (mem_ready) begin
                        fill_d  = mem_rdata;
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    cpu_stall           = 1'b1;
                    sram_memWen         = 1'b1;
                    sram_baddr          = {tag_q, idx_q};
                    sram_din            = fill_q;
                    sram_bytes          = '1;
                    shadow_tag_d[idx_q] = tag_q;
                    valid_d[idx_q]      = 1'b1;
                    state_d             = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            vaddr_q  <= '0;
            victim_q <= '0;
            fill_q   <= '0;
            valid_q  <= '0;
            for (int i = 0; i < NSETS; i++) begin
                shadow_tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            vaddr_q      <= vaddr_d;
            victim_q     <= victim_d;
            fill_q       <= fill_d;
            valid_q      <= valid_d;
            shadow_tag_q <= shadow_tag_d;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized bench for dcache_ctrl with D_SRAM, memory and golden models
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ren, cpu_wen;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sram_ren, sram_wen, sram_memWen;
    logic [7:0]  sram_bytes;
    logic [3:0]  sram_baddr;
    logic [63:0] sram_din;
    logic        sram_hit, sram_dirty;
    logic [63:0] sram_dout;
    logic        mem_req, mem_we;
    logic [3:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
        .sram_bytes(sram_bytes), .sram_baddr(sram_baddr), .sram_din(sram_din),
        .sram_hit(sram_hit), .sram_dirty(sram_dirty), .sram_dout(sram_dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // D_SRAM device stand-in
    logic        sm_valid [2];
    logic        sm_dirty [2];
    logic [2:0]  sm_tag   [2];
    logic [63:0] sm_data  [2];

    always_comb begin
        sram_hit   = sram_ren && sm_valid[sram_baddr[0]] && (sm_tag[sram_baddr[0]] == sram_baddr[3:1]);
        sram_dirty = sm_valid[sram_baddr[0]] && sm_dirty[sram_baddr[0]];
        sram_dout  = sm_data[sram_baddr[0]];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                sm_valid[s] <= 1'b0;
                sm_dirty[s] <= 1'b0;
                sm_tag[s]   <= 3'd0;
                sm_data[s]  <= 64'd0;
            end
        end else if (sram_memWen) begin
            sm_data[sram_baddr[0]]  <= sram_din;
            sm_tag[sram_baddr[0]]   <= sram_baddr[3:1];
            sm_valid[sram_baddr[0]] <= 1'b1;
            sm_dirty[sram_baddr[0]] <= 1'b0;
        end else if (sram_wen) begin
            for (int b = 0; b < 8; b++)
                if (sram_bytes[b]) sm_data[sram_baddr[0]][8*b +: 8] <= sram_din[8*b +: 8];
            sm_dirty[sram_baddr[0]] <= 1'b1;
        end
    end

    // Next-level memory: ready after mem_lat extra cycles of each transaction
    logic [63:0] mem_blk [16];
    int          mem_lat = 0;
    int          mem_cnt = 0;

    always @(negedge clk) begin
        if (!rst || !mem_req) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else begin
            if (mem_ready) mem_cnt = 0;
            if (mem_cnt == mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_blk[mem_addr];
                if (mem_we) mem_blk[mem_addr] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_cnt++;
            end
        end
    end

    // Architectural reference: word memory plus abstract residency per set
    logic [31:0] gmem [32];
    logic        ab_valid [2];
    logic        ab_dirty [2];
    logic [2:0]  ab_tag   [2];

    task automatic reload_golden();
        for (int i = 0; i < 32; i++)
            gmem[i] = i[0] ? mem_blk[i >> 1][63:32] : mem_blk[i >> 1][31:0];
        for (int s = 0; s < 2; s++) begin
            ab_valid[s] = 1'b0;
            ab_dirty[s] = 1'b0;
            ab_tag[s]   = 3'd0;
        end
    endtask

    int          last_stalls, mreq_cycles, fill_cnt;
    logic        saw_wb, saw_rf, strobe_bad, unstable, last_wen;
    logic [3:0]  last_wb_addr, last_rf_addr;
    logic [63:0] last_wb_data;
    logic [31:0] last_rdata;
    logic [7:0]  last_bytes;

    task automatic monitor();
        if (mem_req) begin
            mreq_cycles++;
            if (sram_ren || sram_wen || sram_memWen) strobe_bad = 1'b1;
            if (mem_we) begin
                if (!saw_wb) begin
                    saw_wb = 1'b1; last_wb_addr = mem_addr; last_wb_data = mem_wdata;
                end else if (mem_addr != last_wb_addr || mem_wdata != last_wb_data) unstable = 1'b1;
            end else begin
                if (!saw_rf) begin
                    saw_rf = 1'b1; last_rf_addr = mem_addr;
                end else if (mem_addr != last_rf_addr) unstable = 1'b1;
            end
        end
        if (sram_memWen) fill_cnt++;
        if (sram_memWen && sram_wen) strobe_bad = 1'b1;
    endtask

    task automatic access(input logic ld, input logic st, input logic [6:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int lat);
        int          set, wi, w, vb, exp_stalls, exp_mreq;
        logic        hit, wb;
        logic [63:0] vdata;
        logic [7:0]  eb;
        set  = int'(a[3]);
        wi   = int'(a[6:2]);
        w    = int'(a[2]);
        hit  = ab_valid[set] && (ab_tag[set] == a[6:4]);
        wb   = !hit && ab_valid[set] && ab_dirty[set];
        vb   = int'({ab_tag[set], a[3]});
        vdata = {gmem[vb*2+1], gmem[vb*2]};
        exp_mreq   = hit ? 0 : (lat + 1) + (wb ? lat + 1 : 0);
        exp_stalls = hit ? 0 : exp_mreq + 2;
        eb = {4'b0000, be} << (4 * w);

        mem_lat = lat;
        cpu_ren = ld; cpu_wen = st; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
        last_stalls = 0; mreq_cycles = 0; fill_cnt = 0;
        saw_wb = 1'b0; saw_rf = 1'b0; strobe_bad = 1'b0; unstable = 1'b0;
        @(negedge clk);
        monitor();
        while (cpu_stall && last_stalls < 300) begin
            last_stalls++;
            @(negedge clk);
            monitor();
        end
        last_rdata = cpu_rdata; last_wen = sram_wen; last_bytes = sram_bytes;

        check("stall_cycles", 64'(last_stalls), 64'(exp_stalls));
        check("mem_req_cycles", 64'(mreq_cycles), 64'(exp_mreq));
        check("fill_pulses", 64'(fill_cnt), hit ? 64'd0 : 64'd1);
        check("mem_phase_clean", {strobe_bad, unstable}, 64'd0);
        check("wb_issued", 64'(saw_wb), 64'(wb));
        if (!hit) check("rf_addr", 64'(last_rf_addr), 64'(a[6:3]));
        if (wb) begin
            check("wb_addr", 64'(last_wb_addr), 64'(vb));
            check("wb_data", last_wb_data, vdata);
        end
        if (st) begin
            check("store_wen", 64'(last_wen), 64'd1);
            check("store_bytes", 64'(last_bytes), 64'(eb));
        end else begin
            check("load_data", 64'(last_rdata), 64'(gmem[wi]));
        end

        @(posedge clk);
        #1;
        if (st)
            for (int b = 0; b < 4; b++)
                if (be[b]) gmem[wi][8*b +: 8] = wd[8*b +: 8];
        if (!hit) begin
            ab_valid[set] = 1'b1; ab_tag[set] = a[6:4]; ab_dirty[set] = 1'b0;
        end
        if (st) ab_dirty[set] = 1'b1;
        cpu_ren = 1'b0; cpu_wen = 1'b0;
    endtask

    initial begin
        int op;
        rst = 1'b0;
        cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 7'h00; cpu_wdata = '0; cpu_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem_blk[i] = {$urandom, $urandom};
        mem_blk[0] = 64'hAAAAAAAA_11111111;
        reload_golden();

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_gated", {cpu_stall, sram_ren, mem_req, sram_wen, sram_memWen}, 64'd0);
        cpu_ren = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ctrl", {cpu_stall, mem_req, mem_we, sram_ren, sram_wen, sram_memWen}, 64'd0);
        check("idle_buses", {sram_bytes, sram_baddr, mem_addr, cpu_rdata}, 64'd0);

        access(1'b1, 1'b0, 7'h00, 32'h0, 4'h0, 3);
        check("t2_rdata", 64'(last_rdata), 64'h11111111);
        check("t2_latency", 64'(last_stalls), 64'd6);

        access(1'b0, 1'b1, 7'h04, 32'hFFFFFFFF, 4'hF, 2);
        check("t3_bytes", 64'(last_bytes), 64'hF0);
        access(1'b1, 1'b0, 7'h10, 32'h0, 4'h0, 2);
        check("t3_wb_addr", 64'(last_wb_addr), 64'h0);
        check("t3_wb_data", last_wb_data, 64'hFFFFFFFF_11111111);
        check("t3_rf_addr", 64'(last_rf_addr), 64'h2);

        access(1'b1, 1'b0, 7'h28, 32'h0, 4'h0, 10);
        check("t4_latency", 64'(last_stalls), 64'd13);

        access(1'b1, 1'b1, 7'h10, 32'h12345678, 4'h3, 1);
        check("t6_store_wins", 64'(last_wen), 64'd1);
        access(1'b1, 1'b0, 7'h30, 32'h0, 4'h0, 0);
        check("t6_zero_wait", 64'(last_stalls), 64'd4);

        cpu_ren = 1'b1; cpu_addr = 7'h48; mem_lat = 50;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_async_drop", {mem_req, cpu_stall}, 64'd0);
        cpu_ren = 1'b0;
        reload_golden();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 7'h00, 32'h0, 4'h0, 1);
        check("t5_remiss", 64'(last_stalls), 64'd4);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            access(op < 5 || op == 9, op >= 5, 7'({$urandom_range(0, 31), 2'b00}),
                   $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
